// File: rtl/led_pwm_bank.sv
// -----------------------------------------------------------------------------
// led_pwm_bank
//   Multi-channel registered LED driver. Every channel has a mode
//   (off / on / PWM dim / blink-or-breathe) and a duty value. Both are written
//   through a single-slot ready/valid port. A pending write is committed only
//   on the last cycle of a PWM period, so an LED never sees a partial period.
//
// Build option:
//   LED_BREATHE_EN  undefined : mode 11 = blink, gated by the blink prescaler MSB
//                   defined   : mode 11 = breathe, using a global triangle level
//
// Ports:
//   CLK          system clock
//   RESET_N      asynchronous active-low reset
//   WR_EN        write request (valid)
//   WR_READY     write slot free; a write is taken when WR_EN & WR_READY
//   WR_ADDR      target channel; addresses >= NUM_LEDS are accepted and dropped
//   WR_MODE      00 off, 01 on, 10 PWM, 11 blink/breathe
//   WR_DUTY      duty value (lit while pwm_cnt < duty)
//   LED          registered LED drive, 1 = lit
//   PERIOD_TICK  one-cycle pulse aligned with the last LED cycle of a period
// -----------------------------------------------------------------------------
module led_pwm_bank #(
    parameter int NUM_LEDS  = 8,
    parameter int ADDR_BITS = 3,
    parameter int PWM_BITS  = 8,
    parameter int BLINK_DIV = 24
) (
    input  logic                 CLK,
    input  logic                 RESET_N,
    input  logic                 WR_EN,
    output logic                 WR_READY,
    input  logic [ADDR_BITS-1:0] WR_ADDR,
    input  logic [1:0]           WR_MODE,
    input  logic [PWM_BITS-1:0]  WR_DUTY,
    output logic [NUM_LEDS-1:0]  LED,
    output logic                 PERIOD_TICK
);

    localparam logic [1:0] MODE_OFF = 2'b00;
    localparam logic [1:0] MODE_ON  = 2'b01;
    localparam logic [1:0] MODE_PWM = 2'b10;
    localparam logic [1:0] MODE_ALT = 2'b11;

    localparam logic [PWM_BITS-1:0] PWM_MAX = '1;
    // One extra bit so NUM_LEDS == 2^ADDR_BITS still fits.
    localparam logic [ADDR_BITS:0]  NUM_LEDS_W = NUM_LEDS[ADDR_BITS:0];

    // ---------------------------------------------------------------- counters
    logic [PWM_BITS-1:0] pwm_cnt;
    logic                period_end;

    assign period_end = (pwm_cnt == PWM_MAX);

    // NOTE: sequential state is updated with non-blocking assignments only, so
    // every always_ff sees the pre-edge value of every other register.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            pwm_cnt     <= '0;
            PERIOD_TICK <= 1'b0;
        end else begin
            pwm_cnt     <= pwm_cnt + 1'b1;
            PERIOD_TICK <= period_end;
        end
    end

`ifdef LED_BREATHE_EN
    // Global triangle level shared by every breathing channel: 0 -> max -> 0.
    localparam logic [PWM_BITS-1:0] LVL_TOP = PWM_MAX - 1'b1;
    localparam logic [PWM_BITS-1:0] LVL_BOT = 1;

    logic [PWM_BITS-1:0] breathe_lvl;
    logic                breathe_up;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            breathe_lvl <= '0;
            breathe_up  <= 1'b1;
        end else if (period_end) begin
            if (breathe_up) begin
                breathe_lvl <= breathe_lvl + 1'b1;
                if (breathe_lvl == LVL_TOP) breathe_up <= 1'b0;
            end else begin
                breathe_lvl <= breathe_lvl - 1'b1;
                if (breathe_lvl == LVL_BOT) breathe_up <= 1'b1;
            end
        end
    end
`else
    logic [BLINK_DIV-1:0] blink_cnt;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) blink_cnt <= '0;
        else          blink_cnt <= blink_cnt + 1'b1;
    end
`endif

    // ------------------------------------------------------------ pending slot
    logic                 pend_q;
    logic [ADDR_BITS-1:0] pend_addr_q;
    logic [1:0]           pend_mode_q;
    logic [PWM_BITS-1:0]  pend_duty_q;
    logic                 wr_accept;
    logic                 apply;
    logic                 apply_hit;

    assign WR_READY  = ~pend_q;
    assign wr_accept = WR_EN & ~pend_q;
    // A write taken on the period-end cycle has pend_q = 0 there, so it
    // naturally waits for the following period end.
    assign apply     = period_end & pend_q;
    assign apply_hit = apply & ({1'b0, pend_addr_q} < NUM_LEDS_W);

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            pend_q      <= 1'b0;
            pend_addr_q <= '0;
            pend_mode_q <= MODE_OFF;
            pend_duty_q <= '0;
        end else if (wr_accept) begin
            pend_q      <= 1'b1;
            pend_addr_q <= WR_ADDR;
            pend_mode_q <= WR_MODE;
            pend_duty_q <= WR_DUTY;
        end else if (apply) begin
            pend_q      <= 1'b0;
        end
    end

    // ------------------------------------------------------ per-channel config
    logic [1:0]          mode_q [NUM_LEDS];
    logic [PWM_BITS-1:0] duty_q [NUM_LEDS];

    // NOTE: the config array is reset explicitly because every channel must
    // come up dark; this keeps it in flops rather than a RAM macro.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int i = 0; i < NUM_LEDS; i++) begin
                mode_q[i] <= MODE_OFF;
                duty_q[i] <= '0;
            end
        end else if (apply_hit) begin
            for (int i = 0; i < NUM_LEDS; i++) begin
                if (pend_addr_q == ADDR_BITS'(i)) begin
                    mode_q[i] <= pend_mode_q;
                    duty_q[i] <= pend_duty_q;
                end
            end
        end
    end

    // ------------------------------------------------------------- LED output
`ifdef LED_BREATHE_EN
    function automatic logic [PWM_BITS-1:0] min_lvl(input logic [PWM_BITS-1:0] a,
                                                     input logic [PWM_BITS-1:0] b);
        return (a < b) ? a : b;
    endfunction
`endif

    logic [NUM_LEDS-1:0] led_d;

    // NOTE: led_d gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        led_d = '0;
        for (int i = 0; i < NUM_LEDS; i++) begin
            case (mode_q[i])
                MODE_OFF: led_d[i] = 1'b0;
                MODE_ON:  led_d[i] = 1'b1;
                MODE_PWM: led_d[i] = (pwm_cnt < duty_q[i]);
`ifdef LED_BREATHE_EN
                MODE_ALT: led_d[i] = (pwm_cnt < min_lvl(duty_q[i], breathe_lvl));
`else
                MODE_ALT: led_d[i] = blink_cnt[BLINK_DIV-1] & (pwm_cnt < duty_q[i]);
`endif
                default:  led_d[i] = 1'b0;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) LED <= '0;
        else          LED <= led_d;
    end

endmodule

// File: tb/tb_led_pwm_bank.sv
// -----------------------------------------------------------------------------
// tb_led_pwm_bank
//   Self-checking bench for led_pwm_bank (NUM_LEDS=4, PWM_BITS=4, BLINK_DIV=6,
//   ADDR_BITS=3 so addresses 4..7 are out of range). The reference model works
//   from the cycle index since reset release: PWM phase, blink phase and the
//   breathe level are all derived from it with plain arithmetic, and the write
//   slot is modelled as a queue of at most one entry.
// -----------------------------------------------------------------------------
module tb_led_pwm_bank;

    localparam int NUM_LEDS  = 4;
    localparam int ADDR_BITS = 3;
    localparam int PWM_BITS  = 4;
    localparam int BLINK_DIV = 6;
    localparam int PERIOD    = 1 << PWM_BITS;

    logic                 CLK     = 1'b0;
    logic                 RESET_N = 1'b0;
    logic                 WR_EN   = 1'b0;
    logic                 WR_READY;
    logic [ADDR_BITS-1:0] WR_ADDR = '0;
    logic [1:0]           WR_MODE = '0;
    logic [PWM_BITS-1:0]  WR_DUTY = '0;
    logic [NUM_LEDS-1:0]  LED;
    logic                 PERIOD_TICK;

    always #5 CLK = ~CLK;

    led_pwm_bank #(
        .NUM_LEDS  (NUM_LEDS),
        .ADDR_BITS (ADDR_BITS),
        .PWM_BITS  (PWM_BITS),
        .BLINK_DIV (BLINK_DIV)
    ) dut (
        .CLK         (CLK),
        .RESET_N     (RESET_N),
        .WR_EN       (WR_EN),
        .WR_READY    (WR_READY),
        .WR_ADDR     (WR_ADDR),
        .WR_MODE     (WR_MODE),
        .WR_DUTY     (WR_DUTY),
        .LED         (LED),
        .PERIOD_TICK (PERIOD_TICK)
    );

    // ----------------------------------------------------------------- model
    typedef struct {
        int addr;
        int mode;
        int duty;
    } wr_t;

    wr_t                 pend_q[$];
    int                  m_mode [NUM_LEDS];
    int                  m_duty [NUM_LEDS];
    int                  cyc;
    logic [NUM_LEDS-1:0] exp_led;
    logic                exp_tick;
    logic                exp_ready;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    function automatic void model_reset();
        pend_q.delete();
        for (int i = 0; i < NUM_LEDS; i++) begin
            m_mode[i] = 0;
            m_duty[i] = 0;
        end
        cyc       = 0;
        exp_led   = '0;
        exp_tick  = 1'b0;
        exp_ready = 1'b1;
    endfunction

    // Lit state of a channel for the n-th cycle after reset release.
    function automatic bit lit(input int mode, input int duty, input int n);
        int phase;
        int ends;
        int tri_pos;
        int lvl;
        phase = n % PERIOD;
        case (mode)
            0: return 1'b0;
            1: return 1'b1;
            2: return phase < duty;
            default: begin
`ifdef LED_BREATHE_EN
                ends    = n / PERIOD;
                tri_pos = ends % (2 * (PERIOD - 1));
                lvl     = (tri_pos <= PERIOD - 1) ? tri_pos : 2 * (PERIOD - 1) - tri_pos;
                return phase < ((duty < lvl) ? duty : lvl);
`else
                ends    = 0;
                tri_pos = 0;
                lvl     = 0;
                return ((n % (1 << BLINK_DIV)) >= (1 << (BLINK_DIV - 1))) && (phase < duty);
`endif
            end
        endcase
    endfunction

    // Advance the model across one rising edge, using the inputs held there.
    task automatic model_edge();
        bit was_pend;
        wr_t w;
        if (!RESET_N) begin
            model_reset();
            return;
        end
        for (int i = 0; i < NUM_LEDS; i++) exp_led[i] = lit(m_mode[i], m_duty[i], cyc);
        exp_tick = ((cyc % PERIOD) == PERIOD - 1);
        was_pend = (pend_q.size() != 0);
        if (exp_tick && was_pend) begin
            w = pend_q.pop_front();
            if (w.addr < NUM_LEDS) begin
                m_mode[w.addr] = w.mode;
                m_duty[w.addr] = w.duty;
            end
        end
        if (!was_pend && WR_EN) begin
            w.addr = int'(WR_ADDR);
            w.mode = int'(WR_MODE);
            w.duty = int'(WR_DUTY);
            pend_q.push_back(w);
        end
        exp_ready = (pend_q.size() == 0);
        cyc++;
    endtask

    // ------------------------------------------------------------ stimulus
    task automatic step();
        @(posedge CLK);
        model_edge();
        @(negedge CLK);
        check("led",   32'(LED),         32'(exp_led));
        check("ready", 32'(WR_READY),    32'(exp_ready));
        check("tick",  32'(PERIOD_TICK), 32'(exp_tick));
    endtask

    task automatic run(input int k);
        repeat (k) step();
    endtask

    // Return with the next rising edge seeing pwm_cnt == p (bounded: < PERIOD steps).
    task automatic wait_phase(input int p);
        while ((cyc % PERIOD) != p) step();
    endtask

    task automatic write(input int a, input int m, input int d);
        WR_EN   = 1'b1;
        WR_ADDR = ADDR_BITS'(a);
        WR_MODE = 2'(m);
        WR_DUTY = PWM_BITS'(d);
        step();
        WR_EN   = 1'b0;
    endtask

    initial begin
        model_reset();

        // Reset held with WR_EN toggling: nothing may be accepted.
        for (int i = 0; i < 6; i++) begin
            WR_EN = ~WR_EN;
            WR_MODE = 2'b01;
            step();
        end
        WR_EN   = 1'b0;
        RESET_N = 1'b1;
        run(40);

        // PWM duty 5 on ch1, accepted at pwm_cnt = 3; ignored writes while pending.
        wait_phase(3);
        write(1, 2, 5);
        for (int i = 0; i < 5; i++) write(1, 1, 15);
        run(40);

        // Minimum latency: accepted at pwm_cnt = 14, duty 0 -> dark.
        wait_phase(14);
        write(1, 2, 0);
        run(36);

        // Accepted at pwm_cnt = 15: waits a whole extra period. Duty 15.
        wait_phase(15);
        write(1, 2, 15);
        run(40);

        // Out-of-range address consumes the slot but changes nothing.
        wait_phase(5);
        write(5, 1, 0);
        run(20);
        write(7, 1, 9);
        run(40);

        // Mode 11 on ch0: blink gate (default) or breathe ramp.
`ifdef LED_BREATHE_EN
        write(0, 3, 8);
`else
        write(0, 3, 15);
`endif
        run(32 * PERIOD + 20);
        write(0, 0, 0);
        run(20);

        // Randomised traffic across all modes, duties and addresses.
        for (int i = 0; i < 1500; i++) begin
            WR_EN   = ($urandom_range(0, 3) == 0);
            WR_ADDR = ADDR_BITS'($urandom_range(0, (1 << ADDR_BITS) - 1));
            WR_MODE = 2'($urandom_range(0, 3));
            WR_DUTY = PWM_BITS'($urandom_range(0, PERIOD - 1));
            step();
        end
        WR_EN = 1'b0;
        run(20);

        // Mid-operation reset with ch2 on and a write pending.
        for (int ch = 0; ch < NUM_LEDS; ch++) begin
            write(ch, 0, 0);
            run(PERIOD + 2);
        end
        write(2, 1, 0);
        run(PERIOD + 2);
        wait_phase(2);
        write(3, 1, 0);
        run(3);
        check("pre_rst_led2",  32'(LED[2]),   32'(1));
        check("pre_rst_ready", 32'(WR_READY), 32'(0));
        #2 RESET_N = 1'b0;
        #1;
        check("async_led",   32'(LED),         32'(0));
        check("async_ready", 32'(WR_READY),    32'(1));
        check("async_tick",  32'(PERIOD_TICK), 32'(0));
        model_reset();
        run(3);
        RESET_N = 1'b1;
        run(3 * PERIOD);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
